register_dump: RTL
==================

REGISTER_DUMP -- requirements
Module: register_dump

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of each register word read through the debug port.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port start  input  1  request to begin a dump, sampled only in IDLE.
REQ-005 SHALL have port first_idx  input  5  first register index, latched at accepted start.
REQ-006 SHALL have port last_idx  input  5  final register index, latched at accepted start.
REQ-007 SHALL have port Debug_Source  output  5  register index driven to the register file debug read port.
REQ-008 SHALL have port Debug_Output  input  WIDTH  combinational register file read data for Debug_Source.
REQ-009 SHALL have port out_valid  output  1  out_data/out_idx/out_last hold a valid word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts word when out_valid and out_ready are both 1 on a rising edge.
REQ-011 SHALL have port out_data  output  WIDTH  captured register contents.
REQ-012 SHALL have port out_idx  output  5  index of the register in out_data.
REQ-013 SHALL have port out_last  output  1  word is the final one of the dump.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-016 SHALL implement states IDLE, READ, SEND, DONE.
REQ-017 IDLE: start=1 SHALL latch first_idx into cur_idx and last_idx into end_idx, go to READ; start=0 stays IDLE.
REQ-018 READ (one cycle): Debug_Source SHALL equal cur_idx; at the rising edge, out_data<=Debug_Output, out_idx<=cur_idx, out_last<=(cur_idx==end_idx); go to SEND.
REQ-019 SEND: out_valid SHALL be 1; out_data, out_idx, out_last SHALL stay stable until handshake.
REQ-020 SEND with handshake and out_last=0: cur_idx<=cur_idx+1 modulo 32, go to READ.
REQ-021 SEND with handshake and out_last=1: go to DONE.
REQ-022 DONE (one cycle): done=1, out_valid=0, then go to IDLE.
REQ-023 Debug_Source SHALL be 0 in IDLE, SEND and DONE; out_valid SHALL be 0 outside SEND.
REQ-024 Latency: start sampled at edge n -> READ during cycle n+1 -> out_valid=1 from cycle n+2; maximum throughput one word per 2 cycles.
REQ-025 Wrap-around: first_idx>last_idx SHALL dump first_idx..31 then 0..last_idx, (32-first_idx+last_idx+1) words total.
REQ-026 first_idx==last_idx SHALL produce exactly one word with out_last=1.
REQ-027 Index 0 SHALL be dumped like any other index; the block SHALL forward Debug_Output unmodified.
REQ-028 start while busy=1 SHALL be ignored; changes on first_idx/last_idx after acceptance SHALL have no effect.
REQ-029 out_ready held 0 SHALL stall indefinitely in SEND with no word lost or duplicated.
REQ-030 Register file writes during a dump SHALL be visible only for indices whose READ cycle follows the write.

Reset
REQ-031 reset=0 SHALL immediately, independent of clk, force IDLE, cur_idx=0, end_idx=0, Debug_Source=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
REQ-032 Reset mid-dump SHALL abandon the dump with no done pulse; first rising edge with reset=1 and start=1 starts a fresh dump.

Verification
REQ-033 Regs preloaded x1..x31 = 0x100+i, start with first=0,last=31, out_ready=1 -> 32 words, out_idx 0..31, data 0,0x101..0x11F, out_last only on idx 31, done one cycle after.
REQ-034 first=30,last=1, out_ready=1 -> 4 words with out_idx 30,31,0,1, out_last on idx 1.
REQ-035 first=last=5, x5=0xDEADBEEF -> single word 0xDEADBEEF, out_idx=5, out_last=1, done next cycle.
REQ-036 first=2,last=4, out_ready=0 for 10 cycles at each word -> out_data stable during stall, exactly 3 words delivered in order.
REQ-037 start pulsed again mid-dump with different first/last -> ignored, original sequence completes unchanged.
REQ-038 reset=0 asserted between clock edges during SEND -> all outputs 0 immediately, no done; new start after release dumps from its own first_idx.

Source files
------------

// File: rtl/register_dump.sv
// Walks register indices first_idx..last_idx (wrapping mod 32) through the debug read port and streams each word out.
// Latency: start -> READ next cycle -> out_valid the cycle after; out_valid/out_ready backpressure stalls in SEND without loss.
module register_dump #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       first_idx,
  input  logic [4:0]       last_idx,
  output logic [4:0]       Debug_Source,
  input  logic [WIDTH-1:0] Debug_Output,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cur_idx_q, cur_idx_d;
  logic [4:0]       end_idx_q, end_idx_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [4:0]       out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cur_idx_q  <= '0;
      end_idx_q  <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      end_idx_q  <= end_idx_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    end_idx_d  = end_idx_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_idx_d = first_idx;
          end_idx_d = last_idx;
          state_d   = READ;
        end
      end
      READ: begin
        out_data_d = Debug_Output;
        out_idx_d  = cur_idx_q;
        out_last_d = (cur_idx_q == end_idx_q);
        state_d    = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            // 5-bit increment wraps 31 -> 0 for first_idx > last_idx dumps
            cur_idx_d = cur_idx_q + 5'd1;
            state_d   = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Debug_Source = (state_q == READ) ? cur_idx_q : 5'd0;
  assign out_valid    = (state_q == SEND);
  assign out_data     = out_data_q;
  assign out_idx      = out_idx_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule
